store_drain_ctrl: RTL and testbench

- Sequences retirement of committed stores from the store queue into the data cache write port, one store at a time.
- Tracks how many committed stores are still pending and walks a drain pointer through the circular store queue.
- Defers to loads that request the shared cache port, and frees each queue entry once its write is acknowledged.
- Sits between the commit stage (which reports per-cycle store commit counts) and the D-cache request interface.

---
 rtl/store_drain_ctrl.sv | 126 ++++++++++++
 tb/tb_store_drain_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_ctrl.sv
// Retires committed stores from the circular store queue into the D-cache write port,
// one store at a time, yielding the port to loads at request entry.
module store_drain_ctrl #(
    parameter int unsigned SQ_INDEX     = 4,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid,
    input  logic [CNT_W-1:0]      commit_store_count,
    input  logic [ADDR_WIDTH-1:0] sq_addr,
    input  logic [DATA_WIDTH-1:0] sq_data,
    input  logic                  load_req,
    input  logic                  mem_req_ready,
    input  logic                  mem_ack,
    output logic [SQ_INDEX-1:0]   drain_ptr,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic                  sq_release,
    output logic [SQ_INDEX-1:0]   release_idx,
    output logic [SQ_INDEX:0]     pending,
    output logic                  drain_empty,
    output logic                  overflow_err
);

    // Wide enough for a full queue plus the largest commit burst without wrapping.
    localparam int unsigned SumW = SQ_INDEX + CNT_W + 1;
    localparam logic [SumW-1:0] Cap = SumW'(2 ** SQ_INDEX);

    if ((2 ** CNT_W) <= COMMIT_WIDTH) begin : g_bad_cnt_w
        $error("CNT_W too narrow for COMMIT_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                state_q, state_d;
    logic [SQ_INDEX:0]     pending_q, pending_d;
    logic                  overflow_q, overflow_d;
    logic [SQ_INDEX-1:0]   drain_ptr_q;
    logic [SQ_INDEX-1:0]   release_idx_q;
    logic                  release_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic                  latch_req;
    logic                  ack_taken;
    logic [SumW-1:0]       commit_add;
    logic [SumW-1:0]       sum;

    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Load priority is only consulted here; an issued request is never withdrawn.
                if (pending_q != '0 && !load_req) begin
                    state_d   = StReq;
                    latch_req = 1'b1;
                end
            end
            StReq: begin
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ack_taken  = (state_q == StWait) && mem_ack;
    assign commit_add = commit_valid ? SumW'(commit_store_count) : '0;
    assign sum        = SumW'(pending_q) + commit_add - SumW'(ack_taken);

    always_comb begin
        pending_d  = sum[SQ_INDEX:0];
        overflow_d = overflow_q;
        if (sum > Cap) begin
            pending_d  = Cap[SQ_INDEX:0];
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            drain_ptr_q   <= '0;
            release_idx_q <= '0;
            release_q     <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            req_valid_q <= (state_d == StReq);
            release_q   <= ack_taken;
            if (latch_req) begin
                req_addr_q <= sq_addr;
                req_data_q <= sq_data;
            end
            if (ack_taken) begin
                release_idx_q <= drain_ptr_q;
                drain_ptr_q   <= drain_ptr_q + 1'b1;
            end
        end
    end

    assign drain_ptr     = drain_ptr_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_data  = req_data_q;
    assign sq_release    = release_q;
    assign release_idx   = release_idx_q;
    assign pending       = pending_q;
    assign overflow_err  = overflow_q;
    assign drain_empty   = (pending_q == '0) && (state_q == StIdle);

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Randomized bench for store_drain_ctrl; a transaction-level model of the queue counts,
// drain order and port handshakes predicts every output each cycle.
module tb_store_drain_ctrl;

    localparam int Depth = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid;
    logic [2:0]  commit_store_count;
    logic [31:0] sq_addr;
    logic [31:0] sq_data;
    logic        load_req;
    logic        mem_req_ready;
    logic        mem_ack;
    logic [3:0]  drain_ptr;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        sq_release;
    logic [3:0]  release_idx;
    logic [4:0]  pending;
    logic        drain_empty;
    logic        overflow_err;

    always #5 clk = ~clk;

    store_drain_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .commit_valid       (commit_valid),
        .commit_store_count (commit_store_count),
        .sq_addr            (sq_addr),
        .sq_data            (sq_data),
        .load_req           (load_req),
        .mem_req_ready      (mem_req_ready),
        .mem_ack            (mem_ack),
        .drain_ptr          (drain_ptr),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data       (mem_req_data),
        .sq_release         (sq_release),
        .release_idx        (release_idx),
        .pending            (pending),
        .drain_empty        (drain_empty),
        .overflow_err       (overflow_err)
    );

    // Store queue contents, read combinationally at the DUT's drain pointer.
    logic [31:0] addr_mem [Depth];
    logic [31:0] data_mem [Depth];
    assign sq_addr = addr_mem[drain_ptr];
    assign sq_data = data_mem[drain_ptr];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: counts, drain order, and the handshake phase the bench itself drives.
    int          m_pending, m_ptr, m_rel_idx;
    bit          m_ovf, m_req, m_acc;
    logic [31:0] m_addr, m_data;
    int          ready_pct = 100;
    int          ack_pct   = 100;
    bit          force_ack = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_ptr = 0; m_rel_idx = 0;
        m_ovf = 0; m_req = 0; m_acc = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic step(input bit rst, input bit cv, input int cnt, input bit load);
        bit rdy, ack, ack_taken, issue, exp_rel;
        int sum;
        rdy = m_req && ($urandom_range(99) < ready_pct);
        if (force_ack) ack = 1'b1;
        else if (m_acc) ack = ($urandom_range(99) < ack_pct);
        else ack = !rdy && ($urandom_range(99) < 10);  // stray acks must be ignored
        rst_n              = !rst;
        commit_valid       = cv;
        commit_store_count = 3'(cnt);
        load_req           = load;
        mem_req_ready      = rdy;
        mem_ack            = ack;
        @(posedge clk);
        #1;
        exp_rel = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            ack_taken = m_acc && ack;
            issue     = !m_req && !m_acc && (m_pending > 0) && !load;
            if (issue) begin
                m_addr = addr_mem[m_ptr];
                m_data = data_mem[m_ptr];
            end
            sum = m_pending + (cv ? cnt : 0) - (ack_taken ? 1 : 0);
            if (sum > Depth) begin
                sum   = Depth;
                m_ovf = 1'b1;
            end
            m_pending = sum;
            if (ack_taken) begin
                exp_rel   = 1'b1;
                m_rel_idx = m_ptr;
                m_ptr     = (m_ptr + 1) % Depth;
                m_acc     = 1'b0;
            end
            if (m_req && rdy) begin
                m_req = 1'b0;
                m_acc = 1'b1;
            end else if (issue) begin
                m_req = 1'b1;
            end
        end
        check("pending", pending, m_pending);
        check("overflow_err", overflow_err, m_ovf);
        check("drain_empty", drain_empty, m_pending == 0);
        check("drain_ptr", drain_ptr, m_ptr);
        check("sq_release", sq_release, exp_rel);
        check("release_idx", release_idx, m_rel_idx);
        check("mem_req_valid", mem_req_valid, m_req);
        if (m_req) begin
            check("mem_req_addr", mem_req_addr, m_addr);
            check("mem_req_data", mem_req_data, m_data);
        end
    endtask

    task automatic drain_until_empty();
        for (int i = 0; i < 300 && (m_pending > 0 || m_req || m_acc); i++) step(0, 0, 0, 0);
        check("drain_timeout", (m_pending > 0 || m_req || m_acc), 0);
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) begin
            addr_mem[i] = $urandom;
            data_mem[i] = $urandom;
        end
        addr_mem[0] = 32'h100;
        data_mem[0] = 32'hDEAD;
        model_reset();

        // Reset and idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

        // Single store, prompt handshake
        step(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // Burst of 4 then 3 while draining
        ready_pct = 70; ack_pct = 70;
        step(0, 1, 4, 0);
        step(0, 0, 0, 0);
        step(0, 1, 3, 0);
        drain_until_empty();

        // Load priority at request entry only
        step(0, 1, 2, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        ready_pct = 0;
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        ready_pct = 100;
        drain_until_empty();

        // Walk the pointer to 15, then drain across the wrap
        for (int i = 0; i < 20 && m_ptr != 15; i++) begin
            step(0, 1, 1, 0);
            drain_until_empty();
        end
        check("ptr_at_15", drain_ptr, 15);
        step(0, 1, 2, 0);
        drain_until_empty();

        // Saturation and sticky overflow
        for (int i = 0; i < 5; i++) step(0, 1, 3, 1);
        step(0, 1, 4, 1);
        drain_until_empty();

        // Reset while waiting for the ack, then a late ack
        ack_pct = 0;
        step(0, 1, 1, 0);
        for (int i = 0; i < 10 && !m_acc; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        force_ack = 1'b1;
        step(0, 0, 0, 0);
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Random traffic
        ready_pct = 50; ack_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(99) < 40,
                 int'($urandom_range(4)), $urandom_range(99) < 30);
        end
        drain_until_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
